tx_controller: RTL and testbench
================================

# tx_controller

USB device-side transmit controller; the counterpart of the receive controller on the same USB link. Frames outgoing packets for a downstream byte serializer/NRZI encoder: handshake packets (ACK, NAK) and data packets (DATA0/DATA1 payload drawn from the transmit FIFO). It generates SYNC, PID, payload, CRC-16 and the EOP request. Bit stuffing, NRZI encoding and SE0 signalling belong to the serializer.

## Interface
- MAX_BYTES, 64, maximum payload bytes per data packet (1..1023)
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- send_ack  input  1  one-cycle request: transmit ACK handshake
- send_nack  input  1  one-cycle request: transmit NAK handshake
- send_data  input  1  one-cycle request: transmit data packet from FIFO
- host_ack  input  1  pulse from receive path: host ACKed the last data packet
- toggle_clr  input  1  pulse: force next data PID to DATA0
- fifo_empty  input  1  transmit FIFO empty
- fifo_data  input  8  FIFO head byte (first-word-fall-through)
- fifo_rd  output  1  registered pop pulse to FIFO
- byte_done  input  1  pulse from serializer: loaded byte fully shifted out
- eop_done  input  1  pulse from serializer: EOP finished, line idle
- tx_byte  output  8  registered byte to serializer (LSB transmitted first)
- tx_load  output  1  registered pulse: serializer captures tx_byte
- eop_start  output  1  registered pulse: serializer drives EOP
- tx_busy  output  1  high from request acceptance until tx_done
- tx_done  output  1  one-cycle pulse at packet completion

## Operation
- Reset: state IDLE; tx_byte 0x00, tx_load/fifo_rd/eop_start/tx_busy/tx_done 0; CRC 0xFFFF; count 0; toggle 0 (DATA0); last_was_data 0.
- Byte codes: SYNC 0x80, ACK 0xD2, NAK 0x5A, DATA0 0xC3, DATA1 0x4B.
- Request priority in IDLE: send_ack > send_nack > send_data. Requests outside IDLE ignored, not queued.
- States:
  - IDLE: on request, load SYNC, latch packet type, CRC:=0xFFFF, count:=0 -> SYNC.
  - SYNC: on byte_done, load PID -> PID.
  - PID: on byte_done: handshake -> eop_start -> EOP. Data with fifo_empty -> load ~CRC[7:0] -> CRC_LO. Otherwise load fifo_data, pulse fifo_rd, fold byte into CRC, count:=1 -> DATA.
  - DATA: on byte_done: if fifo_empty or count==MAX_BYTES, load ~CRC[7:0] -> CRC_LO; else load fifo_data, fifo_rd, CRC update, count+1.
  - CRC_LO: on byte_done, load ~CRC[15:8] -> CRC_HI.
  - CRC_HI: on byte_done, eop_start -> EOP.
  - EOP: on eop_done, tx_done pulse, tx_busy low, set last_was_data per packet type -> IDLE.
- CRC-16: reflected polynomial 0xA001 (USB 0x8005), init 0xFFFF, LSB-first byte fold, complemented output, low byte sent first. Zero-length payload sends 0x00, 0x00.
- Toggle: host_ack in IDLE with last_was_data=1 flips toggle and clears last_was_data. toggle_clr forces toggle 0 and wins over a simultaneous host_ack. A handshake packet clears last_was_data.
- Count width $clog2(MAX_BYTES+1); no wrap possible because the limit check precedes increment.
- byte_done/eop_done outside their wait states ignored.

## Timing
- Request sampled cycle N -> tx_load with SYNC and tx_busy high at N+1.
- byte_done sampled cycle M -> next tx_load (or eop_start) at M+1; fifo_data sampled at M, fifo_rd at M+1.
- Serializer guarantees ≥3 cycles between tx_load and byte_done; fifo_empty is valid by then.
- eop_done at cycle K -> tx_done at K+1, tx_busy low at K+1, new request accepted from K+1.
- rst mid-packet: at next edge all outputs return to reset values; no EOP is issued, no FIFO pop.

## Configuration
- TX_DATA_TOGGLE_EN defined: DATA0/DATA1 alternate per the toggle rules above.
- Undefined: toggle logic removed; every data packet uses DATA0; host_ack and toggle_clr ignored.

## Test plan
- send_ack -> tx_byte sequence 0x80, 0xD2, then eop_start; tx_done one cycle after eop_done; fifo_rd never asserted.
- send_data with FIFO holding 0x31..0x39 -> 0x80, 0xC3, 0x31..0x39, 0xC8, 0xB4, eop_start; nine fifo_rd pulses.
- send_data with fifo_empty -> 0x80, 0xC3, 0x00, 0x00, eop_start.
- MAX_BYTES=4, FIFO holding 6 bytes -> exactly 4 payload bytes then CRC; 2 bytes remain in FIFO.
- send_data, eop_done, host_ack, send_data -> second PID 0x4B; toggle_clr+host_ack together before third -> 0xC3 (TX_DATA_TOGGLE_EN defined); undefined -> always 0xC3.
- send_ack and send_data same cycle -> ACK sent; send_nack during DATA ignored; rst asserted in DATA -> all outputs 0 next cycle, state IDLE.

Source files
------------

// File: rtl/tx_controller.sv
// USB device transmit framer: SYNC, PID, FIFO payload, CRC-16, EOP request; optional DATA0/DATA1 toggling under TX_DATA_TOGGLE_EN.
// One-cycle latency from request/byte_done/eop_done to the next output pulse; paced entirely by serializer byte_done/eop_done.
module tx_controller #(
   parameter int MAX_BYTES = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       send_ack,
   input  logic       send_nack,
   input  logic       send_data,
   input  logic       host_ack,
   input  logic       toggle_clr,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   output logic       fifo_rd,
   input  logic       byte_done,
   input  logic       eop_done,
   output logic [7:0] tx_byte,
   output logic       tx_load,
   output logic       eop_start,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int CW = $clog2(MAX_BYTES + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BYTES);

   localparam logic [7:0] SYNC_B  = 8'h80;
   localparam logic [7:0] ACK_B   = 8'hD2;
   localparam logic [7:0] NAK_B   = 8'h5A;
   localparam logic [7:0] DATA0_B = 8'hC3;
   localparam logic [7:0] DATA1_B = 8'h4B;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SYNC   = 3'd1;
   localparam logic [2:0] S_PID    = 3'd2;
   localparam logic [2:0] S_DATA   = 3'd3;
   localparam logic [2:0] S_CRC_LO = 3'd4;
   localparam logic [2:0] S_CRC_HI = 3'd5;
   localparam logic [2:0] S_EOP    = 3'd6;

   logic [2:0]    state;
   logic [15:0]   crc;
   logic [CW-1:0] count;
   logic [7:0]    pid;
   logic          pkt_data;
   logic [7:0]    data_pid;
   logic          any_req;

   // Reflected CRC-16 (0xA001), bits folded LSB first as they go on the wire.
   function automatic logic [15:0] crc_fold(input logic [15:0] c_in, input logic [7:0] b);
      logic [15:0] c;
      c = c_in;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ b[i])
            c = (c >> 1) ^ 16'hA001;
         else
            c = c >> 1;
      end
      return c;
   endfunction

`ifdef TX_DATA_TOGGLE_EN
   logic toggle;
   logic last_was_data;

   assign data_pid = toggle ? DATA1_B : DATA0_B;

   always_ff @(posedge clk) begin
      if (rst) begin
         toggle        <= 1'b0;
         last_was_data <= 1'b0;
      end else begin
         if (toggle_clr)
            toggle <= 1'b0;
         else if (state == S_IDLE && host_ack && last_was_data) begin
            toggle        <= ~toggle;
            last_was_data <= 1'b0;
         end
         if (state == S_EOP && eop_done)
            last_was_data <= pkt_data;
      end
   end
`else
   logic unused_toggle_in;
   assign unused_toggle_in = host_ack | toggle_clr;
   assign data_pid = DATA0_B;
`endif

   assign any_req = send_ack | send_nack | send_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         tx_byte   <= 8'h00;
         tx_load   <= 1'b0;
         fifo_rd   <= 1'b0;
         eop_start <= 1'b0;
         tx_busy   <= 1'b0;
         tx_done   <= 1'b0;
         crc       <= 16'hFFFF;
         count     <= '0;
         pid       <= 8'h00;
         pkt_data  <= 1'b0;
      end else begin
         tx_load   <= 1'b0;
         fifo_rd   <= 1'b0;
         eop_start <= 1'b0;
         tx_done   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  tx_byte  <= SYNC_B;
                  tx_load  <= 1'b1;
                  tx_busy  <= 1'b1;
                  crc      <= 16'hFFFF;
                  count    <= '0;
                  pkt_data <= ~send_ack & ~send_nack;
                  pid      <= send_ack ? ACK_B : (send_nack ? NAK_B : data_pid);
                  state    <= S_SYNC;
               end
            end
            S_SYNC: begin
               if (byte_done) begin
                  tx_byte <= pid;
                  tx_load <= 1'b1;
                  state   <= S_PID;
               end
            end
            S_PID: begin
               if (byte_done) begin
                  if (!pkt_data) begin
                     eop_start <= 1'b1;
                     state     <= S_EOP;
                  end else if (fifo_empty) begin
                     tx_byte <= ~crc[7:0];
                     tx_load <= 1'b1;
                     state   <= S_CRC_LO;
                  end else begin
                     tx_byte <= fifo_data;
                     tx_load <= 1'b1;
                     fifo_rd <= 1'b1;
                     crc     <= crc_fold(crc, fifo_data);
                     count   <= CW'(1);
                     state   <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               // Limit check comes before the increment, so count never wraps.
               if (byte_done) begin
                  if (fifo_empty || count == MAX_CNT) begin
                     tx_byte <= ~crc[7:0];
                     tx_load <= 1'b1;
                     state   <= S_CRC_LO;
                  end else begin
                     tx_byte <= fifo_data;
                     tx_load <= 1'b1;
                     fifo_rd <= 1'b1;
                     crc     <= crc_fold(crc, fifo_data);
                     count   <= count + 1'b1;
                  end
               end
            end
            S_CRC_LO: begin
               if (byte_done) begin
                  tx_byte <= ~crc[15:8];
                  tx_load <= 1'b1;
                  state   <= S_CRC_HI;
               end
            end
            S_CRC_HI: begin
               if (byte_done) begin
                  eop_start <= 1'b1;
                  state     <= S_EOP;
               end
            end
            S_EOP: begin
               if (eop_done) begin
                  tx_done <= 1'b1;
                  tx_busy <= 1'b0;
                  state   <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tx_controller.sv
// Bench for tx_controller: two instances (MAX_BYTES 64 and 4), bench-side serializer/FIFO and packet reference model.
module tb_tx_controller;

   logic            clk;
   logic            rst;
   logic [1:0]      send_ack, send_nack, send_data;
   logic            host_ack, toggle_clr, fifo_empty, byte_done, eop_done;
   logic [7:0]      fifo_data;
   logic [1:0]      fifo_rd, tx_load, eop_start, tx_busy, tx_done;
   logic [1:0][7:0] tx_byte;

   int   n_checks;
   int   n_fail;
   int   fq[$];
   int   tog[2];
   int   lwd[2];

   tx_controller #(.MAX_BYTES(64)) dut0 (
      .clk(clk), .rst(rst), .send_ack(send_ack[0]), .send_nack(send_nack[0]), .send_data(send_data[0]),
      .host_ack(host_ack), .toggle_clr(toggle_clr), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
      .fifo_rd(fifo_rd[0]), .byte_done(byte_done), .eop_done(eop_done), .tx_byte(tx_byte[0]),
      .tx_load(tx_load[0]), .eop_start(eop_start[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]));

   tx_controller #(.MAX_BYTES(4)) dut1 (
      .clk(clk), .rst(rst), .send_ack(send_ack[1]), .send_nack(send_nack[1]), .send_data(send_data[1]),
      .host_ack(host_ack), .toggle_clr(toggle_clr), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
      .fifo_rd(fifo_rd[1]), .byte_done(byte_done), .eop_done(eop_done), .tx_byte(tx_byte[1]),
      .tx_load(tx_load[1]), .eop_start(eop_start[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int max_of(input int d);
      return (d == 0) ? 64 : 4;
   endfunction

   function automatic int data_pid(input int d);
`ifdef TX_DATA_TOGGLE_EN
      return (tog[d] != 0) ? 'h4B : 'hC3;
`else
      return (d >= 0) ? 'hC3 : 'hC3;
`endif
   endfunction

   task automatic fifo_drive();
      fifo_empty = (fq.size() == 0);
      fifo_data  = (fq.size() == 0) ? 8'h00 : 8'(fq[0]);
   endtask

   task automatic fifo_fill(input int first, input int n, input bit rnd);
      fq.delete();
      for (int i = 0; i < n; i++)
         fq.push_back(rnd ? int'($urandom_range(0, 255)) : first + i);
      fifo_drive();
   endtask

   // Transmit one packet on instance d acting as serializer/FIFO; req = {data, nack, ack}.
   task automatic run_packet(input int d, input logic [2:0] req, input int inj, input string nm, output int pid_seen);
      int exp[$];
      int got[$];
      int n, rd_cnt, start_sz, bd_t, eop_t, late, bad_idx, dummy;
      logic [15:0] c;
      logic [7:0]  b;
      logic bd_prev, eop_prev, fin, injd, ok, is_data;

      is_data  = !req[0] && !req[1];
      start_sz = fq.size();
      n = 0;
      exp.push_back('h80);
      if (req[0]) exp.push_back('hD2);
      else if (req[1]) exp.push_back('h5A);
      else begin
         exp.push_back(data_pid(d));
         n = (start_sz < max_of(d)) ? start_sz : max_of(d);
         c = 16'hFFFF;
         for (int i = 0; i < n; i++) begin
            b = 8'(fq[i]);
            exp.push_back(fq[i]);
            for (int k = 0; k < 8; k++)
               c = (c[0] ^ b[k]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
         end
         c = ~c;
         exp.push_back(int'(c[7:0]));
         exp.push_back(int'(c[15:8]));
      end
      exp.push_back(256);

      @(negedge clk);
      send_ack[d] = req[0]; send_nack[d] = req[1]; send_data[d] = req[2];
      @(posedge clk); #1;
      n_checks++;
      if (tx_load[d] !== 1'b1 || tx_byte[d] !== 8'h80 || tx_busy[d] !== 1'b1) begin
         n_fail++;
         $display("FAIL %s req_latency: load=%0b byte=%h busy=%0b, want 1 80 1", nm, tx_load[d], tx_byte[d], tx_busy[d]);
      end
      send_ack[d] = 1'b0; send_nack[d] = 1'b0; send_data[d] = 1'b0;

      bd_t = 0; eop_t = 0; late = 0; rd_cnt = 0;
      bd_prev = 0; eop_prev = 0; fin = 0; injd = 0;
      for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
         @(negedge clk);
         byte_done = 1'b0; eop_done = 1'b0; send_nack[d] = 1'b0;
         if (fifo_rd[d]) begin
            rd_cnt++;
            if (fq.size() > 0) dummy = fq.pop_front();
         end
         fifo_drive();
         if (bd_prev && !(tx_load[d] || eop_start[d])) late++;
         if (eop_prev) begin
            n_checks++;
            if (tx_done[d] !== 1'b1 || tx_busy[d] !== 1'b0) begin
               n_fail++;
               $display("FAIL %s done_timing: tx_done=%0b tx_busy=%0b, want 1 0", nm, tx_done[d], tx_busy[d]);
            end
            fin = 1;
         end
         bd_prev = 0; eop_prev = 0;
         if (tx_load[d]) begin
            got.push_back(int'(tx_byte[d]));
            bd_t = 3;
         end else if (bd_t > 0) begin
            bd_t--;
            if (bd_t == 0) begin byte_done = 1'b1; bd_prev = 1; end
         end
         if (eop_start[d]) begin
            got.push_back(256);
            eop_t = 3;
         end else if (eop_t > 0) begin
            eop_t--;
            if (eop_t == 0) begin eop_done = 1'b1; eop_prev = 1; end
         end
         if (inj > 0 && !injd && got.size() == inj) begin
            send_nack[d] = 1'b1;
            injd = 1;
         end
      end
      byte_done = 1'b0; eop_done = 1'b0; send_nack[d] = 1'b0;

      n_checks++;
      if (!fin) begin
         n_fail++;
         $display("FAIL %s timeout: packet not completed, %0d events seen", nm, got.size());
      end
      ok = (got.size() == exp.size());
      bad_idx = -1;
      for (int i = 0; i < exp.size() && ok; i++)
         if (got[i] != exp[i]) begin ok = 0; bad_idx = i; end
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s sequence: got %0d events, want %0d; first diff at %0d got %h want %h", nm, got.size(), exp.size(),
                  bad_idx, (bad_idx >= 0) ? got[bad_idx] : -1, (bad_idx >= 0) ? exp[bad_idx] : -1);
      end
      n_checks++;
      if (rd_cnt != n || fq.size() != start_sz - n) begin
         n_fail++;
         $display("FAIL %s fifo_pops: pops=%0d left=%0d, want pops=%0d left=%0d", nm, rd_cnt, fq.size(), n, start_sz - n);
      end
      n_checks++;
      if (late != 0) begin
         n_fail++;
         $display("FAIL %s byte_latency: %0d late responses, want 0", nm, late);
      end
      pid_seen = (got.size() > 1) ? got[1] : -1;
`ifdef TX_DATA_TOGGLE_EN
      lwd[d] = is_data ? 1 : 0;
`endif
   endtask

   task automatic pulse_ctrl(input logic ha, input logic tc);
      @(negedge clk);
      host_ack = ha; toggle_clr = tc;
      @(posedge clk); #1;
      host_ack = 1'b0; toggle_clr = 1'b0;
`ifdef TX_DATA_TOGGLE_EN
      for (int d = 0; d < 2; d++) begin
         if (tc) tog[d] = 0;
         else if (ha && lwd[d] != 0) begin tog[d] = 1 - tog[d]; lwd[d] = 0; end
      end
`endif
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if ({tx_byte[d], tx_load[d], fifo_rd[d], eop_start[d], tx_busy[d], tx_done[d]} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_outputs dut%0d: byte=%h load=%0b rd=%0b eop=%0b busy=%0b done=%0b, want all 0",
                     d, tx_byte[d], tx_load[d], fifo_rd[d], eop_start[d], tx_busy[d], tx_done[d]);
         end
         tog[d] = 0; lwd[d] = 0;
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_handshakes();
      int p;
      fifo_fill(0, 0, 0);
      run_packet(0, 3'b001, 0, "ack", p);
      run_packet(0, 3'b010, 0, "nak", p);
      fifo_fill('h10, 2, 0);
      run_packet(0, 3'b101, 0, "ack_over_data", p);
      fq.delete(); fifo_drive();
   endtask

   task automatic test_data();
      int p;
      fifo_fill('h31, 9, 0);
      run_packet(0, 3'b100, 0, "data_nine", p);
      fifo_fill(0, 0, 0);
      run_packet(0, 3'b100, 0, "data_empty", p);
      fifo_fill('h50, 6, 0);
      run_packet(1, 3'b100, 0, "data_max4", p);
      n_checks++;
      if (fq.size() != 2) begin
         n_fail++;
         $display("FAIL data_max4_left: %0d bytes left, want 2", fq.size());
      end
      fifo_fill('h60, 5, 0);
      run_packet(0, 3'b100, 4, "nak_ignored_in_data", p);
      fq.delete(); fifo_drive();
   endtask

   task automatic test_toggle();
      int p1, p2, p3;
      pulse_ctrl(1'b0, 1'b1);
      fifo_fill('hA0, 2, 0);
      run_packet(0, 3'b100, 0, "tog_first", p1);
      pulse_ctrl(1'b1, 1'b0);
      fifo_fill('hB0, 2, 0);
      run_packet(0, 3'b100, 0, "tog_second", p2);
      pulse_ctrl(1'b1, 1'b1);
      fifo_fill('hC0, 2, 0);
      run_packet(0, 3'b100, 0, "tog_third", p3);
      fq.delete(); fifo_drive();
      n_checks++;
`ifdef TX_DATA_TOGGLE_EN
      if (p1 != 'hC3 || p2 != 'h4B || p3 != 'hC3) begin
`else
      if (p1 != 'hC3 || p2 != 'hC3 || p3 != 'hC3) begin
`endif
         n_fail++;
         $display("FAIL toggle_pids: got %h %h %h", p1, p2, p3);
      end
   endtask

   task automatic test_rst_mid_packet();
      int cnt, bd_t, dummy, p;
      fifo_fill('h31, 5, 0);
      @(negedge clk);
      send_data[0] = 1'b1;
      @(negedge clk);
      send_data[0] = 1'b0;
      cnt = 0; bd_t = 0;
      for (int cyc = 0; cyc < 200 && cnt < 4; cyc++) begin
         byte_done = 1'b0;
         if (fifo_rd[0] && fq.size() > 0) dummy = fq.pop_front();
         fifo_drive();
         if (tx_load[0]) begin cnt++; bd_t = 3; end
         else if (bd_t > 0) begin bd_t--; if (bd_t == 0) byte_done = 1'b1; end
         if (cnt < 4) @(negedge clk);
      end
      byte_done = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (cnt != 4 || {tx_byte[0], tx_load[0], fifo_rd[0], eop_start[0], tx_busy[0], tx_done[0]} !== 13'h0) begin
         n_fail++;
         $display("FAIL rst_mid_outputs: loads=%0d byte=%h load=%0b rd=%0b eop=%0b busy=%0b, want 4 loads and all 0",
                  cnt, tx_byte[0], tx_load[0], fifo_rd[0], eop_start[0], tx_busy[0]);
      end
      @(negedge clk);
      rst = 1'b0;
      tog[0] = 0; lwd[0] = 0; tog[1] = 0; lwd[1] = 0;
      cnt = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         byte_done = (cyc % 2 == 0);
         eop_done  = (cyc % 4 == 1);
         if (tx_load[0] || eop_start[0] || fifo_rd[0] || tx_busy[0] || tx_done[0]) cnt++;
      end
      byte_done = 1'b0; eop_done = 1'b0;
      n_checks++;
      if (cnt != 0) begin
         n_fail++;
         $display("FAIL rst_mid_idle: %0d cycles with activity after reset, want 0", cnt);
      end
      fq.delete(); fifo_drive();
      run_packet(0, 3'b001, 0, "ack_after_rst", p);
   endtask

   task automatic test_random();
      int d, p;
      logic [2:0] req;
      for (int it = 0; it < 12; it++) begin
         d = int'($urandom_range(0, 1));
         req = 3'($urandom_range(1, 7));
         if ($urandom_range(0, 1) == 1) req = 3'b100;
         fifo_fill(0, int'($urandom_range(0, 10)), 1);
         run_packet(d, req, 0, "random", p);
         fq.delete(); fifo_drive();
         pulse_ctrl(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      end
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      rst = 1'b1;
      send_ack = '0; send_nack = '0; send_data = '0;
      host_ack = 1'b0; toggle_clr = 1'b0; byte_done = 1'b0; eop_done = 1'b0;
      fq.delete();
      fifo_drive();
      test_reset();
      test_handshakes();
      test_data();
      test_toggle();
      test_rst_mid_packet();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
